// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM encoding, flag bundle.
package alu_pkg;

    // Opcode map, unchanged from the 4-bit combinational ALU.
    localparam logic [2:0] OP_NEGA = 3'b000;
    localparam logic [2:0] OP_NEGB = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } aluState;

    // Status flags, packed as {z, n, c, v}.
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } aluFlags;

    // True for the four opcodes that go through the shared adder.
    function automatic logic isArith(input logic [2:0] opCode);
        return opCode inside {OP_NEGA, OP_NEGB, OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic               done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] accNext;
    logic [CW-1:0]      count;
    logic               busy;
    logic               lastStep;

    // Next accumulator value: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
        addend = '0;
        if (mplier[count]) begin
            addend = {{WIDTH{1'b0}}, mcand} << count;
        end
        accNext  = acc + addend;
        lastStep = busy && (count == CW'(WIDTH - 1));
    end

    // prod is the finished product only while done is high, so the caller can
    // register it on the same edge that performs the final partial-product add.
    assign prod = accNext;
    assign done = lastStep;

    // Operand capture on start, then one partial-product step per cycle until the last bit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc   <= accNext;
            count <= count + CW'(1);
            if (lastStep) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with status flags, valid/ready handshakes and an iterative multiplier.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    aluState            state;
    logic               inReady;
    logic               outValid;
    logic [WIDTH-1:0]   resultReg;
    logic [WIDTH-1:0]   resultHiReg;
    aluFlags            flagsReg;

    logic [WIDTH-1:0]   addX;
    logic [WIDTH-1:0]   addY;
    logic               addCin;
    logic [WIDTH:0]     sumFull;
    logic               carryMsb;
    logic [WIDTH-1:0]   opResult;
    aluFlags            opFlags;

    logic               mulStart;
    logic               mulDone;
    logic [2*WIDTH-1:0] mulProd;
    aluFlags            mulFlags;

    assign mulStart = (state == ST_IDLE) && in_valid && (op == OP_MUL);

    seq_multiplier #(.WIDTH(WIDTH)) u_mult (
        .clk   (clk),
        .reset (reset),
        .start (mulStart),
        .a     (a),
        .b     (b),
        .prod  (mulProd),
        .done  (mulDone)
    );

    // Operand steering into the single shared adder.
    always_comb begin
        addX   = a;
        addY   = b;
        addCin = 1'b0;
        case (op)
            OP_NEGA: begin addX = ~a; addY = '0; addCin = 1'b1; end
            OP_NEGB: begin addX = ~b; addY = '0; addCin = 1'b1; end
            OP_SUB:  begin addY = ~b; addCin = 1'b1; end
            default: ;
        endcase
    end

    // Adder, logic ops and flag generation for single-cycle opcodes; MUL flags from the product.
    always_comb begin
        sumFull  = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
        // Carry into the MSB recovered from the MSB sum bit and the MSB operand bits.
        carryMsb = sumFull[WIDTH-1] ^ addX[WIDTH-1] ^ addY[WIDTH-1];

        case (op)
            OP_AND:  opResult = a & b;
            OP_OR:   opResult = a | b;
            OP_XOR:  opResult = a ^ b;
            default: opResult = sumFull[WIDTH-1:0];
        endcase

        opFlags.z = (opResult == '0);
        opFlags.n = opResult[WIDTH-1];
        opFlags.c = isArith(op) ? sumFull[WIDTH] : 1'b0;
        opFlags.v = isArith(op) ? (carryMsb ^ sumFull[WIDTH]) : 1'b0;

        mulFlags.z = (mulProd[WIDTH-1:0] == '0);
        mulFlags.n = mulProd[WIDTH-1];
        mulFlags.c = (mulProd[2*WIDTH-1:WIDTH] != '0);
        mulFlags.v = (mulProd[2*WIDTH-1:WIDTH] != '0);
    end

    // Control FSM with registered handshake outputs, result and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            inReady     <= 1'b1;
            outValid    <= 1'b0;
            resultReg   <= '0;
            resultHiReg <= '0;
            flagsReg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        inReady <= 1'b0;
                        if (op == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            state       <= ST_HOLD;
                            outValid    <= 1'b1;
                            resultReg   <= opResult;
                            resultHiReg <= '0;
                            flagsReg    <= opFlags;
                        end
                    end
                end
                ST_MUL: begin
                    if (mulDone) begin
                        state       <= ST_HOLD;
                        outValid    <= 1'b1;
                        resultReg   <= mulProd[WIDTH-1:0];
                        resultHiReg <= mulProd[2*WIDTH-1:WIDTH];
                        flagsReg    <= mulFlags;
                    end
                end
                ST_HOLD: begin
                    // Returning to IDLE first keeps accept and consume in separate cycles.
                    if (out_ready) begin
                        state    <= ST_IDLE;
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = inReady;
    assign out_valid = outValid;
    assign result    = resultReg;
    assign result_hi = resultHiReg;
    assign flag_z    = flagsReg.z;
    assign flag_n    = flagsReg.n;
    assign flag_c    = flagsReg.c;
    assign flag_v    = flagsReg.v;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed vector table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_seq_alu;

    localparam int  W    = 8;
    localparam longint MOD  = 64'd1 << W;
    localparam longint HALF = 64'd1 << (W - 1);

    localparam logic [2:0] T_NEGA = 3'd0;
    localparam logic [2:0] T_NEGB = 3'd1;
    localparam logic [2:0] T_ADD  = 3'd2;
    localparam logic [2:0] T_SUB  = 3'd3;
    localparam logic [2:0] T_AND  = 3'd4;
    localparam logic [2:0] T_OR   = 3'd5;
    localparam logic [2:0] T_MUL  = 3'd6;
    localparam logic [2:0] T_XOR  = 3'd7;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   flg;   // {z,n,c,v}
        int           lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] curFlags();
        return {flag_z, flag_n, flag_c, flag_v};
    endfunction

    // Reference model: plain integer arithmetic on the opcode definitions.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic [W-1:0] h, output logic [3:0] f);
        longint ua, ub, sa, sb, full, lo, hiv, sres;
        logic c, v;
        ua = longint'(x);
        ub = longint'(y);
        sa = (ua >= HALF) ? ua - MOD : ua;
        sb = (ub >= HALF) ? ub - MOD : ub;
        hiv = 0;
        c = 1'b0;
        v = 1'b0;
        case (o)
            T_NEGA: begin lo = (MOD - ua) % MOD; c = (ua == 0); sres = -sa; v = (sres >= HALF); end
            T_NEGB: begin lo = (MOD - ub) % MOD; c = (ub == 0); sres = -sb; v = (sres >= HALF); end
            T_ADD:  begin full = ua + ub; lo = full % MOD; c = (full >= MOD);
                          sres = sa + sb; v = (sres >= HALF) || (sres < -HALF); end
            T_SUB:  begin lo = (ua - ub + MOD) % MOD; c = (ua >= ub);
                          sres = sa - sb; v = (sres >= HALF) || (sres < -HALF); end
            T_AND:  lo = ua & ub;
            T_OR:   lo = ua | ub;
            T_XOR:  lo = ua ^ ub;
            default: begin full = ua * ub; lo = full % MOD; hiv = full / MOD;
                           c = (hiv != 0); v = (hiv != 0); end
        endcase
        r = W'(lo);
        h = W'(hiv);
        f = {(lo == 0), (lo >= HALF), c, v};
    endtask

    // Issue one operation, wait for out_valid (bounded), capture outputs, hold, then consume.
    task automatic runOp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold, output logic [W-1:0] r, output logic [W-1:0] h,
                         output logic [3:0] f, output int lat);
        logic badReady;
        check("in_ready before issue", in_ready, 1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        lat = 1;
        badReady = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) badReady = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("in_ready low while busy", badReady, 0);
        r = result;
        h = result_hi;
        f = curFlags();
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid after consume", out_valid, 0);
        check("in_ready after consume", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, h, er, eh;
        logic [3:0]   f, ef;
        int           lat;
        int           bad;

        vecs[0]  = '{T_ADD,  8'd200, 8'd100, 8'd44,  8'd0,   4'b0010, 1};
        vecs[1]  = '{T_SUB,  8'd5,   8'd7,   8'd254, 8'd0,   4'b0100, 1};
        vecs[2]  = '{T_ADD,  8'd127, 8'd1,   8'd128, 8'd0,   4'b0101, 1};
        vecs[3]  = '{T_MUL,  8'd15,  8'd17,  8'd255, 8'd0,   4'b0100, 9};
        vecs[4]  = '{T_MUL,  8'd16,  8'd16,  8'd0,   8'd1,   4'b1011, 9};
        vecs[5]  = '{T_MUL,  8'd255, 8'd255, 8'd1,   8'd254, 4'b0011, 9};
        vecs[6]  = '{T_NEGA, 8'd0,   8'd9,   8'd0,   8'd0,   4'b1010, 1};
        vecs[7]  = '{T_NEGB, 8'd77,  8'd1,   8'd255, 8'd0,   4'b0100, 1};
        vecs[8]  = '{T_AND,  8'hF0,  8'h3C,  8'h30,  8'd0,   4'b0000, 1};
        vecs[9]  = '{T_OR,   8'hF0,  8'h3C,  8'hFC,  8'd0,   4'b0100, 1};
        vecs[10] = '{T_XOR,  8'hF0,  8'h3C,  8'hCC,  8'd0,   4'b0100, 1};
        vecs[11] = '{T_MUL,  8'd0,   8'd200, 8'd0,   8'd0,   4'b1000, 9};
        vecs[12] = '{T_MUL,  8'd37,  8'd0,   8'd0,   8'd0,   4'b1000, 9};
        vecs[13] = '{T_NEGA, 8'h80,  8'd0,   8'h80,  8'd0,   4'b0101, 1};
        vecs[14] = '{T_SUB,  8'd9,   8'd9,   8'd0,   8'd0,   4'b1010, 1};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset result", result, 0);
        check("reset result_hi", result_hi, 0);
        check("reset flags", curFlags(), 0);

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, i % 3, r, h, f, lat);
            check($sformatf("vec%0d result", i), r, vecs[i].res);
            check($sformatf("vec%0d result_hi", i), h, vecs[i].hi);
            check($sformatf("vec%0d flags", i), f, vecs[i].flg);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
        end

        // Backpressure: OR result held 5 cycles while a competing request is presented.
        in_valid = 1'b1; op = T_OR; a = 8'hF0; b = 8'h3C;
        @(posedge clk); #1;
        op = T_ADD; a = 8'd3; b = 8'd4;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'hFC ||
                result_hi !== 8'd0 || curFlags() !== 4'b0100) bad++;
        end
        check("hold stable under backpressure", bad, 0);
        // Consume while the request is still high: it must not be accepted in this cycle.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("no accept on consume cycle: out_valid", out_valid, 0);
        check("no accept on consume cycle: in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accept after idle: out_valid", out_valid, 1);
        check("accept after idle: result", result, 7);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        check("ignored request not queued", bad, 0);

        // Reset in cycle 4 of an 8-cycle multiply.
        in_valid = 1'b1; op = T_MUL; a = 8'd255; b = 8'd255;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid-MUL reset out_valid", out_valid, 0);
        check("mid-MUL reset in_ready", in_ready, 1);
        check("mid-MUL reset result", result, 0);
        check("mid-MUL reset result_hi", result_hi, 0);
        check("mid-MUL reset flags", curFlags(), 0);
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        check("aborted MUL produces no result", bad, 0);
        runOp(T_ADD, 8'd1, 8'd1, 0, r, h, f, lat);
        check("post-reset ADD result", r, 2);
        check("post-reset ADD latency", lat, 1);

        // Reset in HOLD beats a simultaneous consume and a new request.
        in_valid = 1'b1; op = T_XOR; a = 8'hAA; b = 8'h0F;
        @(posedge clk); #1;
        op = T_ADD; a = 8'd9; b = 8'd9;
        out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("HOLD reset out_valid", out_valid, 0);
        check("HOLD reset result", result, 0);
        check("HOLD reset in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("HOLD reset stays idle", out_valid, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 3'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 10 == 0) ra = 8'hFF;
            if (i % 15 == 0) rb = 8'h80;
            model(ro, ra, rb, er, eh, ef);
            runOp(ro, ra, rb, int'($urandom_range(2, 0)), r, h, f, lat);
            check($sformatf("rand%0d op%0d a=%0d b=%0d result", i, ro, ra, rb), r, er);
            check($sformatf("rand%0d op%0d a=%0d b=%0d result_hi", i, ro, ra, rb), h, eh);
            check($sformatf("rand%0d op%0d a=%0d b=%0d flags", i, ro, ra, rb), f, ef);
            check($sformatf("rand%0d latency", i), lat, (ro == T_MUL) ? W + 1 : 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
